// File: rtl/bip_debug_unit.sv
// Debug/sequencing controller for the BIP CPU: UART-driven program load, run-to-HALT, single step, state dump.
// Optional inter-byte load timeout enabled by defining BIP_DBG_LOAD_TIMEOUT_EN.
module bip_debug_unit #(
  parameter int NBITS_D = 16,
  parameter int NBITS_A = 11,
  parameter int OPCODE = 5,
  parameter logic [OPCODE-1:0] HALT_OP = 5'b00000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_prog_we,
  output logic [NBITS_A-1:0] o_prog_addr,
  output logic [NBITS_D-1:0] o_prog_data,
  output logic               o_cpu_en,
  output logic               o_cpu_rst,
  input  logic [NBITS_A-1:0] i_cpu_pc,
  input  logic [NBITS_D-1:0] i_cpu_acc,
  input  logic [NBITS_D-1:0] i_cpu_instr,
  output logic               o_busy
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD_HI  = 4'd1,
    ST_LOAD_LO  = 4'd2,
    ST_WRITE    = 4'd3,
    ST_RUN_RST  = 4'd4,
    ST_RUN      = 4'd5,
    ST_STEP     = 4'd6,
    ST_DUMP_CAP = 4'd7,
    ST_TX_SEND  = 4'd8,
    ST_TX_WAIT  = 4'd9
  } state_t;

  localparam logic [NBITS_A-1:0] ADDR_MAX = {NBITS_A{1'b1}};
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;

  state_t               state_r;
  logic [NBITS_A-1:0]   addr_r;
  logic [NBITS_D-1:0]   prog_data_r;
  logic                 prog_we_r;
  logic [15:0]          cnt_r;
  logic [47:0]          snap_r;
  logic [2:0]           byte_idx_r;
  logic [7:0]           tx_data_r;
  logic                 tx_start_r;
  logic                 cpu_en_r;
  logic                 cpu_rst_r;
  logic                 busy_r;
  logic                 to_hit_s;
  logic [OPCODE-1:0]    cpu_op_s;
  logic [OPCODE-1:0]    wr_op_s;

  assign cpu_op_s = i_cpu_instr[NBITS_D-1 -: OPCODE];
  assign wr_op_s  = prog_data_r[NBITS_D-1 -: OPCODE];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] dump_byte(input logic [47:0] snap, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = snap[47:40];
      3'd1:    b = snap[39:32];
      3'd2:    b = snap[31:24];
      3'd3:    b = snap[23:16];
      3'd4:    b = snap[15:8];
      3'd5:    b = snap[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef BIP_DBG_LOAD_TIMEOUT_EN
  logic [31:0] to_cnt_r;
  logic        unused_s;

  assign to_hit_s = (to_cnt_r == 32'(TIMEOUT_CYCLES - 1));
  assign unused_s = &{1'b0, i_cpu_instr[NBITS_D-OPCODE-1:0]};

  // Inter-byte idle counter, restarted by every received byte and outside the load states.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      to_cnt_r <= 32'd0;
    end else if ((state_r == ST_LOAD_HI || state_r == ST_LOAD_LO) && !i_rx_done) begin
      to_cnt_r <= to_cnt_r + 32'd1;
    end else begin
      to_cnt_r <= 32'd0;
    end
  end
`else
  logic unused_s;

  assign to_hit_s = 1'b0;
  assign unused_s = &{1'b0, i_cpu_instr[NBITS_D-OPCODE-1:0], TIMEOUT_CYCLES[0]};
`endif

  // Main sequencer: command decode, program load, run/step control and dump transmission.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      prog_data_r <= '0;
      prog_we_r   <= 1'b0;
      cnt_r       <= 16'd0;
      snap_r      <= 48'd0;
      byte_idx_r  <= 3'd0;
      tx_data_r   <= 8'h00;
      tx_start_r  <= 1'b0;
      cpu_en_r    <= 1'b0;
      cpu_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      prog_we_r  <= 1'b0;
      tx_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_rx_done) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state_r   <= ST_LOAD_HI;
                cpu_rst_r <= 1'b1;
                addr_r    <= '0;
                busy_r    <= 1'b1;
              end
              CMD_RUN: begin
                state_r   <= ST_RUN_RST;
                cpu_rst_r <= 1'b1;
                cnt_r     <= 16'd0;
                busy_r    <= 1'b1;
              end
              CMD_STEP: begin
                state_r   <= ST_STEP;
                cpu_rst_r <= 1'b0;
                cpu_en_r  <= 1'b1;
                busy_r    <= 1'b1;
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_LOAD_HI: begin
          if (i_rx_done) begin
            prog_data_r <= {i_rx_data, prog_data_r[7:0]};
            state_r     <= ST_LOAD_LO;
          end else if (to_hit_s) begin
            addr_r  <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD_LO: begin
          if (i_rx_done) begin
            prog_data_r <= {prog_data_r[15:8], i_rx_data};
            prog_we_r   <= 1'b1;
            state_r     <= ST_WRITE;
          end else if (to_hit_s) begin
            addr_r  <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          // A HALT word or the last address ends the load.
          if (wr_op_s == HALT_OP || addr_r == ADDR_MAX) begin
            addr_r  <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            addr_r  <= addr_r + 1'b1;
            state_r <= ST_LOAD_HI;
          end
        end
        ST_RUN_RST: begin
          cpu_rst_r <= 1'b0;
          cpu_en_r  <= 1'b1;
          state_r   <= ST_RUN;
        end
        ST_RUN: begin
          cnt_r <= sat_inc(cnt_r);
          if (cpu_en_r && cpu_op_s == HALT_OP) begin
            cpu_en_r <= 1'b0;
            state_r  <= ST_DUMP_CAP;
          end
        end
        ST_STEP: begin
          cpu_en_r <= 1'b0;
          cnt_r    <= sat_inc(cnt_r);
          state_r  <= ST_DUMP_CAP;
        end
        ST_DUMP_CAP: begin
          // CPU is disabled here, so PC/ACC are stable for the snapshot.
          snap_r     <= {{(16-NBITS_A){1'b0}}, i_cpu_pc, 16'(i_cpu_acc), cnt_r};
          byte_idx_r <= 3'd0;
          state_r    <= ST_TX_SEND;
        end
        ST_TX_SEND: begin
          tx_data_r  <= dump_byte(snap_r, byte_idx_r);
          tx_start_r <= 1'b1;
          state_r    <= ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          if (i_tx_done) begin
            if (byte_idx_r == 3'd5) begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              byte_idx_r <= byte_idx_r + 3'd1;
              state_r    <= ST_TX_SEND;
            end
          end
        end
        default: begin
          cpu_en_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_data   = tx_data_r;
  assign o_tx_start  = tx_start_r;
  assign o_prog_we   = prog_we_r;
  assign o_prog_addr = addr_r;
  assign o_prog_data = prog_data_r;
  assign o_cpu_en    = cpu_en_r;
  assign o_cpu_rst   = cpu_rst_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Scoreboard bench for bip_debug_unit: expected tx bytes and program writes are queued by the
// stimulus and popped by a monitor; a CPU stub and a UART-tx model close the loop.
module tb_bip_debug_unit;

`ifdef BIP_DBG_LOAD_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 50_000_000;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_done = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done = 1'b0;
  logic        o_prog_we;
  logic [10:0] o_prog_addr;
  logic [15:0] o_prog_data;
  logic        o_cpu_en;
  logic        o_cpu_rst;
  logic [10:0] i_cpu_pc;
  logic [15:0] i_cpu_acc;
  logic [15:0] i_cpu_instr;
  logic        o_busy;

  bip_debug_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr), .o_prog_data(o_prog_data),
    .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst),
    .i_cpu_pc(i_cpu_pc), .i_cpu_acc(i_cpu_acc), .i_cpu_instr(i_cpu_instr),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;
  int en_cycles = 0;
  int tx_delay = 3;
  bit stub_halt_en = 1'b1;
  logic [10:0] stub_pc = 11'd0;
  logic [7:0]  exp_tx[$];
  logic [26:0] exp_wr[$];

  // CPU stub: PC advances per enabled cycle, HALT word at address 2, ACC constant.
  assign i_cpu_instr = (stub_halt_en && stub_pc == 11'd2) ? 16'h0000 : 16'h0805;
  assign i_cpu_acc   = 16'h0008;
  assign i_cpu_pc    = stub_pc;
  always @(posedge i_clk) begin
    if (o_cpu_rst) stub_pc <= 11'd0;
    else if (o_cpu_en && i_cpu_instr[15:11] != 5'b00000) stub_pc <= stub_pc + 11'd1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops for tx bytes and program writes, counts enabled CPU cycles.
  initial forever begin
    @(negedge i_clk);
    if (o_cpu_en) en_cycles++;
    if (o_tx_start) begin
      if (exp_tx.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_unexpected: got byte %0h, expected no transmission", o_tx_data);
      end else check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_tx.pop_front()});
    end
    if (o_prog_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write", o_prog_addr, o_prog_data);
      end else check("prog_write", {5'd0, o_prog_addr, o_prog_data}, {5'd0, exp_wr.pop_front()});
    end
  end

  // UART tx model: answers each start with a done pulse after tx_delay cycles, flags overlap.
  initial forever begin
    @(negedge i_clk);
    if (o_tx_start) begin
      repeat (tx_delay) begin
        @(negedge i_clk);
        check("tx_overlap", {31'd0, o_tx_start}, 32'd0);
      end
      i_tx_done = 1'b1;
      @(negedge i_clk);
      i_tx_done = 1'b0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max_cycles);
    int k = 0;
    while (o_busy && k < max_cycles) begin
      @(negedge i_clk);
      k++;
    end
    check(nm, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic push_dump(input logic [15:0] pc, input logic [15:0] acc, input logic [15:0] cnt);
    exp_tx.push_back(pc[15:8]);  exp_tx.push_back(pc[7:0]);
    exp_tx.push_back(acc[15:8]); exp_tx.push_back(acc[7:0]);
    exp_tx.push_back(cnt[15:8]); exp_tx.push_back(cnt[7:0]);
  endtask

  logic [7:0] load_seq [7] = '{8'h4C, 8'h08, 8'h05, 8'h18, 8'h03, 8'h00, 8'h00};

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
    check("rst_cpu_en", {31'd0, o_cpu_en}, 32'd0);
    check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_prog_we", {31'd0, o_prog_we}, 32'd0);
    check("rst_prog_addr", {21'd0, o_prog_addr}, 32'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);

    // Load three words; the HALT word ends the load.
    exp_wr.push_back({11'd0, 16'h0805});
    exp_wr.push_back({11'd1, 16'h1803});
    exp_wr.push_back({11'd2, 16'h0000});
    foreach (load_seq[i]) begin
      send_byte(load_seq[i]);
      repeat (3) @(negedge i_clk);
    end
    wait_idle("load_idle", 50);
    check("load_writes_left", exp_wr.size(), 32'd0);
    check("load_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
    check("load_addr_reset", {21'd0, o_prog_addr}, 32'd0);

    // Run to HALT at address 2: three enabled cycles.
    en_cycles = 0;
    push_dump(16'h0002, 16'h0008, 16'h0003);
    send_byte(8'h52);
    wait_idle("run_idle", 300);
    check("run_en_cycles", en_cycles, 32'd3);
    check("run_tx_left", exp_tx.size(), 32'd0);
    check("run_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);

    // Unknown byte is ignored.
    send_byte(8'h41);
    repeat (5) @(negedge i_clk);
    check("unknown_busy", {31'd0, o_busy}, 32'd0);
    check("unknown_en", en_cycles, 32'd3);

    // Slow tx handshake with an R injected during the dump.
    tx_delay = 100;
    en_cycles = 0;
    push_dump(16'h0002, 16'h0008, 16'h0004);
    send_byte(8'h53);
    repeat (20) @(negedge i_clk);
    send_byte(8'h52);
    wait_idle("slow_idle", 1500);
    check("slow_tx_left", exp_tx.size(), 32'd0);
    repeat (10) @(negedge i_clk);
    check("inject_busy", {31'd0, o_busy}, 32'd0);
    check("inject_en_cycles", en_cycles, 32'd1);
    tx_delay = 3;

    // Asynchronous reset in the middle of a non-halting run.
    stub_halt_en = 1'b0;
    send_byte(8'h52);
    repeat (10) @(negedge i_clk);
    check("midrun_en", {31'd0, o_cpu_en}, 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("async_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
    check("async_cpu_en", {31'd0, o_cpu_en}, 32'd0);
    check("async_tx_start", {31'd0, o_tx_start}, 32'd0);
    check("async_busy", {31'd0, o_busy}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    stub_halt_en = 1'b1;

    // Two steps from reset: counts 1 and 2.
    en_cycles = 0;
    push_dump(16'h0001, 16'h0008, 16'h0001);
    send_byte(8'h53);
    wait_idle("step1_idle", 300);
    check("step1_en", en_cycles, 32'd1);
    en_cycles = 0;
    push_dump(16'h0002, 16'h0008, 16'h0002);
    send_byte(8'h53);
    wait_idle("step2_idle", 300);
    check("step2_en", en_cycles, 32'd1);
    check("step_tx_left", exp_tx.size(), 32'd0);

`ifdef BIP_DBG_LOAD_TIMEOUT_EN
    send_byte(8'h4C);
    repeat (3) @(negedge i_clk);
    send_byte(8'h08);
    repeat (10) @(negedge i_clk);
    check("timeout_not_early", {31'd0, o_busy}, 32'd1);
    wait_idle("timeout_idle", 20);
    check("timeout_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
    check("timeout_addr", {21'd0, o_prog_addr}, 32'd0);
`endif

    repeat (5) @(negedge i_clk);
    check("final_tx_left", exp_tx.size(), 32'd0);
    check("final_wr_left", exp_wr.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
